// File: rtl/digit_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial add/sub unit.
// The master drives the request; the slave returns status and results.
interface digit_serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB digit first.
// Flags (cout, ovf, zero) and sum update together on the last digit.
module digit_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digit_serial_addsub_if.slave  s
);
    localparam int NSTEP = WIDTH / DIGIT;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int OW    = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [SW-1:0]    r_step;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_done;

    logic             w_busy;
    logic             w_cap;
    logic             w_run;
    logic             w_last;
    logic [OW-1:0]    w_off;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic [DIGIT:0]   w_slice;
    logic             w_cin_msb;
    logic [WIDTH-1:0] w_fin;

    assign w_run  = (r_state == S_RUN);
    assign w_cap  = (r_state == S_IDLE) && s.start;
    assign w_last = (r_step == SW'(NSTEP - 1));

    // Digit slice: operand digits plus running carry; carry into the
    // top bit is recovered from the sum bit and the two operand bits.
    always_comb begin
        w_off     = OW'(DIGIT) * OW'(r_step);
        w_da      = r_a[w_off +: DIGIT];
        w_db      = r_b[w_off +: DIGIT];
        w_slice   = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_c};
        w_cin_msb = w_slice[DIGIT-1] ^ w_da[DIGIT-1] ^ w_db[DIGIT-1];
        w_fin     = r_res;
        w_fin[w_off +: DIGIT] = w_slice[DIGIT-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: launch on start, return to idle after the last digit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (s.start) w_next = S_RUN;
            S_RUN:   if (w_last)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    // Operand capture and per-digit accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_c    <= 1'b0;
            r_step <= '0;
        end else if (w_cap) begin
            r_a    <= s.a;
            r_b    <= s.b ^ {WIDTH{s.sub}};
            r_c    <= s.sub;
            r_step <= '0;
        end else if (w_run) begin
            r_res[w_off +: DIGIT] <= w_slice[DIGIT-1:0];
            r_c    <= w_slice[DIGIT];
            r_step <= w_last ? '0 : r_step + SW'(1);
        end
    end

    // Result and flag registers, updated only on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_run && w_last;
            if (w_run && w_last) begin
                r_sum  <= w_fin;
                r_cout <= w_slice[DIGIT];
                r_ovf  <= w_cin_msb ^ w_slice[DIGIT];
                r_zero <= (w_fin == '0);
            end
        end
    end

    assign s.busy = w_busy;
    assign s.done = r_done;
    assign s.sum  = r_sum;
    assign s.cout = r_cout;
    assign s.ovf  = r_ovf;
    assign s.zero = r_zero;

endmodule
